// File: rtl/regbank_wrbuf_pkg.sv
// Shared definitions for the register-file write buffer.
//   REG_AW  - register-file address width
//   REG_DW  - register-file data width
//   state_t - controller state: CLEAR (zeroing the register file) or RUN
package regbank_wrbuf_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

endpackage

// File: rtl/regbank_wrbuf_fifo.sv
// Circular write buffer holding pending register-file writes.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   push, push_addr/data  - append an entry at the tail
//   pop                   - drop the head entry
//   count                 - number of entries held (0..DEPTH)
//   rd_ptr                - index of the head (oldest) entry
//   head_addr, head_data  - contents of the head entry
//   ent_addr/data/valid   - every slot, for read forwarding
module regbank_wrbuf_fifo
    import regbank_wrbuf_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [REG_AW-1:0]             push_addr,
    input  logic [REG_DW-1:0]             push_data,
    input  logic                          pop,
    output logic [CNT_W-1:0]              count,
    output logic [PTR_W-1:0]              rd_ptr,
    output logic [REG_AW-1:0]             head_addr,
    output logic [REG_DW-1:0]             head_data,
    output logic [DEPTH-1:0][REG_AW-1:0]  ent_addr,
    output logic [DEPTH-1:0][REG_DW-1:0]  ent_data,
    output logic [DEPTH-1:0]              ent_valid
);

    logic [PTR_W-1:0]             wr_ptr;
    logic [DEPTH-1:0][REG_AW-1:0] addr_q;
    logic [DEPTH-1:0][REG_DW-1:0] data_q;
    logic [DEPTH-1:0]             valid_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                wr_ptr          <= wr_ptr + PTR_W'(1);
                valid_q[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr          <= rd_ptr + PTR_W'(1);
                valid_q[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the payload array has no reset; valid_q alone says which slots
    // hold live data, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
    assign ent_addr  = addr_q;
    assign ent_data  = data_q;
    assign ent_valid = valid_q;

endmodule

// File: rtl/regbank_wrbuf.sv
// Register-file front end: clears all NREG registers after reset, then
// buffers write requests and retires one per cycle in acceptance order,
// forwarding buffered data to the two read ports.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   req_valid/ready/addr/data  - write request handshake
//   rf_write, rf_dr, rf_wrData - register-file write port
//   sr1, sr2                   - read addresses (shared with register file)
//   rf_rdData1, rf_rdData2     - raw register-file read data
//   rdData1, rdData2           - read data including buffered writes
//   init_done                  - clear sequence has finished
//   pending                    - entries currently buffered
module regbank_wrbuf
    import regbank_wrbuf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NREG  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [REG_AW-1:0]          req_addr,
    input  logic [REG_DW-1:0]          req_data,
    output logic                       rf_write,
    output logic [REG_AW-1:0]          rf_dr,
    output logic [REG_DW-1:0]          rf_wrData,
    input  logic [REG_AW-1:0]          sr1,
    input  logic [REG_AW-1:0]          sr2,
    input  logic [REG_DW-1:0]          rf_rdData1,
    input  logic [REG_DW-1:0]          rf_rdData2,
    output logic [REG_DW-1:0]          rdData1,
    output logic [REG_DW-1:0]          rdData2,
    output logic                       init_done,
    output logic [$clog2(DEPTH):0]     pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    state_t                       state, state_nxt;
    logic [REG_AW-1:0]            clr_cnt;
    logic                         push, pop;
    logic [CNT_W-1:0]             count;
    logic [PTR_W-1:0]             rd_ptr;
    logic [REG_AW-1:0]            head_addr;
    logic [REG_DW-1:0]            head_data;
    logic [DEPTH-1:0][REG_AW-1:0] ent_addr;
    logic [DEPTH-1:0][REG_DW-1:0] ent_data;
    logic [DEPTH-1:0]             ent_valid;

    regbank_wrbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (req_addr),
        .push_data (req_data),
        .pop       (pop),
        .count     (count),
        .rd_ptr    (rd_ptr),
        .head_addr (head_addr),
        .head_data (head_data),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .ent_valid (ent_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR)
                clr_cnt <= clr_cnt + REG_AW'(1);
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        rf_write  = 1'b0;
        rf_dr     = '0;
        rf_wrData = '0;
        req_ready = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_CLEAR: begin
                rf_write = 1'b1;
                rf_dr    = clr_cnt;
                if (clr_cnt == REG_AW'(NREG - 1))
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Full blocks acceptance even when the head retires this cycle.
                req_ready = (count != CNT_W'(DEPTH));
                if (count != '0) begin
                    pop       = 1'b1;
                    rf_write  = 1'b1;
                    rf_dr     = head_addr;
                    rf_wrData = head_data;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign push      = req_valid & req_ready;
    assign init_done = (state == ST_RUN);
    assign pending   = count;

    // Walk entries oldest to youngest; the last match is the youngest write.
    // The head stays valid until the retiring edge, so it still forwards.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        rdData1 = rf_rdData1;
        rdData2 = rf_rdData2;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (ent_valid[idx] && ent_addr[idx] == sr1) rdData1 = ent_data[idx];
            if (ent_valid[idx] && ent_addr[idx] == sr2) rdData2 = ent_data[idx];
        end
    end

endmodule

// File: tb/tb_regbank_wrbuf.sv
module tb_regbank_wrbuf;

    localparam int DEPTH = 4;
    localparam int NREG  = 32;

    logic        clk = 1'b1;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic        rf_write;
    logic [4:0]  rf_dr;
    logic [31:0] rf_wrData;
    logic [4:0]  sr1 = '0, sr2 = '0;
    logic [31:0] rf_rdData1, rf_rdData2;
    logic [31:0] rdData1, rdData2;
    logic        init_done;
    logic [2:0]  pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regbank_wrbuf #(.DEPTH(DEPTH), .NREG(NREG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .rf_write   (rf_write),
        .rf_dr      (rf_dr),
        .rf_wrData  (rf_wrData),
        .sr1        (sr1),
        .sr2        (sr2),
        .rf_rdData1 (rf_rdData1),
        .rf_rdData2 (rf_rdData2),
        .rdData1    (rdData1),
        .rdData2    (rdData2),
        .init_done  (init_done),
        .pending    (pending)
    );

    // 32x32 register file driven by the DUT's write port
    logic [31:0] rf_mem [32];
    always @(posedge clk) if (rf_write) rf_mem[rf_dr] <= rf_wrData;
    assign rf_rdData1 = rf_mem[sr1];
    assign rf_rdData2 = rf_mem[sr2];

    // Reference model: a queue of pending writes plus an expected register file
    typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;
    ent_t        q[$];
    int          clear_idx = 0;
    logic [31:0] ref_rf [32];

    typedef struct {
        logic v; logic [4:0] a; logic [31:0] d; logic [4:0] s1, s2;
        logic e_w; logic [4:0] e_dr; logic [31:0] e_wd, e_rd1, e_rd2; int e_pend;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] sr);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].addr == sr) return q[i].data;
        return ref_rf[sr];
    endfunction

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] s1, input logic [4:0] s2);
        @(negedge clk);
        req_valid = v; req_addr = a; req_data = d; sr1 = s1; sr2 = s2;
        #1;
    endtask

    // Compare outputs with the model for the current cycle, then advance one edge.
    task automatic model_cycle();
        logic acc;
        if (clear_idx < NREG) begin
            check("clr_write", 32'(rf_write), 1);
            check("clr_dr", 32'(rf_dr), 32'(clear_idx));
            check("clr_data", rf_wrData, 0);
            check("clr_ready", 32'(req_ready), 0);
            check("clr_init", 32'(init_done), 0);
            check("clr_pending", 32'(pending), 0);
        end else begin
            check("run_write", 32'(rf_write), 32'(q.size() > 0));
            check("run_dr", 32'(rf_dr), q.size() > 0 ? 32'(q[0].addr) : 0);
            check("run_data", rf_wrData, q.size() > 0 ? q[0].data : 0);
            check("run_ready", 32'(req_ready), 32'(q.size() < DEPTH));
            check("run_init", 32'(init_done), 1);
            check("run_pending", 32'(pending), 32'(q.size()));
        end
        check("rdData1", rdData1, exp_rd(sr1));
        check("rdData2", rdData2, exp_rd(sr2));
        acc = (clear_idx >= NREG) && req_valid && (q.size() < DEPTH);
        @(posedge clk);
        if (clear_idx < NREG) begin
            ref_rf[clear_idx] = 0;
            clear_idx++;
        end else begin
            if (q.size() > 0) begin
                ref_rf[q[0].addr] = q[0].data;
                void'(q.pop_front());
            end
            if (acc) q.push_back('{addr: req_addr, data: req_data});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            model_cycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = 32'hDEAD_0000 | 32'(i);
            ref_rf[i] = rf_mem[i];
        end

        // Reset state, before any clock edge
        #2;
        check("rst_pending", 32'(pending), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_init", 32'(init_done), 0);
        check("rst_dr", 32'(rf_dr), 0);
        rst_n = 1'b1;

        // Clear sequence with requests offered that must be ignored
        for (int i = 0; i < NREG; i++) begin
            drive(1'b1, 5'($urandom_range(0, 31)), $urandom, 5'(i), 5'd31);
            model_cycle();
        end

        // Back-to-back writes, hand-computed expectations (register file all zero)
        tbl[0] = '{1, 1, 'hA, 1, 2, 0, 0, 0,   0,   0,   0};
        tbl[1] = '{1, 2, 'hB, 1, 2, 1, 1, 'hA, 'hA, 0,   1};
        tbl[2] = '{1, 3, 'hC, 1, 2, 1, 2, 'hB, 'hA, 'hB, 1};
        tbl[3] = '{1, 1, 'hD, 1, 2, 1, 3, 'hC, 'hA, 'hB, 1};
        tbl[4] = '{0, 0, 0,   1, 2, 1, 1, 'hD, 'hD, 'hB, 1};
        tbl[5] = '{0, 0, 0,   1, 2, 0, 0, 0,   'hD, 'hB, 0};
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].s1, tbl[i].s2);
            check($sformatf("tbl%0d_write", i), 32'(rf_write), 32'(tbl[i].e_w));
            check($sformatf("tbl%0d_dr", i), 32'(rf_dr), 32'(tbl[i].e_dr));
            check($sformatf("tbl%0d_wd", i), rf_wrData, tbl[i].e_wd);
            check($sformatf("tbl%0d_rd1", i), rdData1, tbl[i].e_rd1);
            check($sformatf("tbl%0d_rd2", i), rdData2, tbl[i].e_rd2);
            check($sformatf("tbl%0d_pend", i), 32'(pending), 32'(tbl[i].e_pend));
            model_cycle();
        end
        check("r1_final", rf_mem[1], 32'hD);

        // Forwarding before the write reaches the register file
        drive(1'b1, 5'd5, 32'h1234, 5'd5, 5'd0);
        model_cycle();
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        check("fwd_rd1", rdData1, 32'h1234);
        check("fwd_rf_not_yet", 32'(rf_rdData1 != 32'h1234), 1);
        check("fwd_dr", 32'(rf_dr), 5);
        model_cycle();
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        check("fwd_rf_written", rf_rdData1, 32'h1234);
        model_cycle();

        // Two writes to r7, both ports reading r7
        drive(1'b1, 5'd7, 32'h11, 5'd7, 5'd7); model_cycle();
        drive(1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
        check("r7_head_rd1", rdData1, 32'h11);
        model_cycle();
        drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
        check("r7_young_rd1", rdData1, 32'h22);
        check("r7_young_rd2", rdData2, 32'h22);
        model_cycle();
        drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
        check("r7_rf_rd1", rdData1, 32'h22);
        check("r7_rf_rd2", rdData2, 32'h22);
        check("r7_rf", rf_mem[7], 32'h22);
        check("r7_empty", 32'(pending), 0);
        model_cycle();

        // Continuous valid, then randomized traffic
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            check("pend_bound", 32'(pending <= 3'(DEPTH)), 1);
            model_cycle();
        end
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            model_cycle();
        end
        idle(3);

        // Reset with a write buffered; it must never reach the register file
        drive(1'b1, 5'd9, 32'h5555, 5'd9, 5'd10);
        model_cycle();
        drive(1'b1, 5'd10, 32'h6666, 5'd9, 5'd10);
        check("prerst_pend", 32'(pending), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_pend", 32'(pending), 0);
        check("midrst_ready", 32'(req_ready), 0);
        check("midrst_init", 32'(init_done), 0);
        check("midrst_dr", 32'(rf_dr), 0);
        rst_n = 1'b1;
        #1;
        q.delete();
        clear_idx = 0;
        model_cycle();
        for (int i = 1; i < NREG; i++) begin
            drive(1'b1, 5'($urandom_range(0, 31)), $urandom, 5'd9, 5'd10);
            model_cycle();
        end
        idle(3);
        check("r9_discarded", rf_mem[9], 0);
        check("r10_discarded", rf_mem[10], 0);

        for (int i = 0; i < 32; i++) check($sformatf("rf_final%0d", i), rf_mem[i], ref_rf[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
